spi_bar_receiver: RTL and testbench
===================================

# spi_bar_receiver

Upstream feeder for the VGA bar-graph display. Receives 16-bit SPI write packets from the GPIO header, oversampling the slow, asynchronous SPI lines in the 50 MHz pixel domain. Packets update a shadow register file of per-bar heights. The file is copied to the display-facing register bank only on a frame-commit pulse, so a bar never changes mid-frame. Its output bank drives the bar comparators of the VGA timing/colour stage directly.

## Interface

Parameters:
- N, 15, number of bars / 8-bit height registers
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input (minimum 2)

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; all logic on rising edge
- KEY0  in  1  reset. Synchronous, active-low; board KEY[0].
- spi_clk  in  1  SPI clock (GPIO[0]), asynchronous, idle low, max 6.25 MHz
- csel  in  1  frame enable (GPIO[2]), active-high, asynchronous
- mosi  in  1  serial data (GPIO[4]), asynchronous, valid on spi_clk rising edge
- commit  in  1  one-cycle pulse from the VGA stage at vertical-sync start
- bars  out  N*8  display bank; bar i = bars[8*i+7 : 8*i]
- wr_strobe  out  1  one-cycle pulse when a valid packet updates the shadow file
- pkt_err  out  1  one-cycle pulse when a frame is rejected
- err_count  out  8  rejected-frame count, saturating

## Operation

- Each SPI input passes through SYNC_STAGES flops, then one history flop.
- rise = synced spi_clk high AND history low.
- csel_fall = synced csel low AND previous synced csel high.
- Packet bit order is LSB-first. Shift on each rise: pkt <= {mosi_s, pkt[15:1]}.
- After 16 bits: pkt[7:0] = address, pkt[15:8] = data.
- 5-bit bit counter, saturating at 17.
- FSM states:
  - ARM: wait for synced csel low. Reset enters ARM, so a frame already in progress at reset release is ignored. Synced csel low -> IDLE.
  - IDLE: synced csel high -> SHIFT; clear bit counter and pkt.
  - SHIFT: shift and count on each rise. csel_fall -> CHECK.
  - CHECK: one cycle, then IDLE.
    - Valid when bit count == 16 and address < N. Write shadow[address] <= data and pulse wr_strobe.
    - Otherwise pulse pkt_err and increment err_count (holds at 255). Shadow is unchanged.
- Rising spi_clk edges while not in SHIFT are ignored.
- Commit: on a commit cycle, bars <= shadow (all N entries at once). bars is otherwise held.
- Commit coinciding with a CHECK write: the commit copies the pre-write shadow. The new value appears at the next commit.
- Address is compared as an unsigned 8-bit value. Address 0xFF is rejected, never aliased.

## Timing

- Reset (KEY0 low at a clock edge): shadow, bars, err_count = 0; wr_strobe, pkt_err = 0; pkt = 0; FSM = ARM.
- A pin edge reaches rise/csel_fall after SYNC_STAGES+1 cycles (3 with defaults).
- Last SCK edge to CHECK: csel may fall no earlier than half an SPI period after the last rising SCK edge. Both edges pass through equal synchroniser depth, so ordering is preserved.
- csel_fall -> CHECK on the next cycle. wr_strobe/pkt_err are asserted in the CHECK cycle (registered); the shadow update is visible the cycle after.
- Commit pulse -> bars updated on the following cycle.
- Minimum SPI high and low times are 4 CLOCK_50 cycles each, i.e. spi_clk ≤ 6.25 MHz. Faster clocks are unsupported and may drop bits; those frames are rejected by the count check.
- Minimum csel high time is 16 SPI periods. Minimum csel low time between frames is 4 CLOCK_50 cycles.

## Test plan

- Reset then commit:
  - bars = 0, err_count = 0, no strobes.
  - Send address 3, data 0xA5: wr_strobe pulses once, bars unchanged.
  - Pulse commit: bars[31:24] = 0xA5, every other byte 0.
- Bad frame lengths:
  - 15-bit frame: pkt_err pulses, err_count = 1, shadow unchanged.
  - 17-bit frame: pkt_err, err_count = 2.
  - 16-bit frame with address 15 (N=15): pkt_err, err_count = 3.
- Write/commit collision: address 0 holds 0x10. Send address 0, data 0x20, and align commit with the CHECK cycle. bars[7:0] = 0x10 after that commit and 0x20 after the next.
- Reset mid-frame: KEY0 low after 8 bits with csel still high, released before the frame ends. Remaining bits are ignored; no wr_strobe, no pkt_err. The next full frame to address 14, data 0xFF, followed by commit, gives bars[119:112] = 0xFF.
- Saturation: 300 15-bit frames -> err_count = 255, and pkt_err still pulses per frame.
- Back-to-back throughput: 15 frames at 6.25 MHz with 4-cycle csel gaps, addresses 0..14, data = 2*address. 15 wr_strobes; after commit each bar i equals 2i.

Source files
------------

// File: rtl/spi_bar_receiver.sv
// SPI write port for the VGA bar-graph display. Slow SPI lines are oversampled
// in the pixel clock domain. The display bank only changes on a frame-commit pulse.
module spi_bar_receiver #(
    parameter int N           = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic           CLOCK_50,
    input  logic           KEY0,
    input  logic           spi_clk,
    input  logic           csel,
    input  logic           mosi,
    input  logic           commit,
    output logic [N*8-1:0] bars,
    output logic           wr_strobe,
    output logic           pkt_err,
    output logic [7:0]     err_count
);
    localparam logic [7:0] N_ADDR   = 8'(N);
    localparam logic [4:0] BIT_FULL = 5'd16;
    localparam logic [4:0] BIT_SAT  = 5'd17;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2,
        CHECK = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] csel_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_hist_r;
    logic                   csel_hist_r;
    logic                   sclk_s;
    logic                   csel_s;
    logic                   mosi_s;
    logic                   rise_s;
    logic                   csel_fall_s;
    logic                   frame_ok_s;
    state_t                 state_r;
    logic [15:0]            pkt_r;
    logic [4:0]             bit_cnt_r;
    logic [7:0]             shadow_r [N];

    // Synchronisers keep running through reset so a frame already in flight
    // at reset release still looks like "csel high" and is skipped in ARM.
    always_ff @(posedge CLOCK_50) begin
        sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_clk};
        csel_sync_r <= {csel_sync_r[SYNC_STAGES-2:0], csel};
        mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
        sclk_hist_r <= sclk_s;
        csel_hist_r <= csel_s;
    end

    // Edge detection and frame validity on the synchronised lines.
    always_comb begin
        sclk_s      = sclk_sync_r[SYNC_STAGES-1];
        csel_s      = csel_sync_r[SYNC_STAGES-1];
        mosi_s      = mosi_sync_r[SYNC_STAGES-1];
        rise_s      = sclk_s & ~sclk_hist_r;
        csel_fall_s = ~csel_s & csel_hist_r;
        frame_ok_s  = (bit_cnt_r == BIT_FULL) && (pkt_r[7:0] < N_ADDR);
    end

    // Receive FSM. The strobes are decided on csel_fall so they are high
    // exactly during the CHECK cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            state_r   <= ARM;
            pkt_r     <= 16'd0;
            bit_cnt_r <= 5'd0;
            wr_strobe <= 1'b0;
            pkt_err   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            wr_strobe <= 1'b0;
            pkt_err   <= 1'b0;
            case (state_r)
                ARM: begin
                    if (!csel_s) begin
                        state_r <= IDLE;
                    end
                end
                IDLE: begin
                    if (csel_s) begin
                        state_r   <= SHIFT;
                        bit_cnt_r <= 5'd0;
                        pkt_r     <= 16'd0;
                    end
                end
                SHIFT: begin
                    if (csel_fall_s) begin
                        state_r   <= CHECK;
                        wr_strobe <= frame_ok_s;
                        pkt_err   <= ~frame_ok_s;
                        if (!frame_ok_s && (err_count != 8'hFF)) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else if (rise_s) begin
                        pkt_r <= {mosi_s, pkt_r[15:1]};
                        if (bit_cnt_r != BIT_SAT) begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                CHECK: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= ARM;
                end
            endcase
        end
    end

    // Shadow write lands at the end of CHECK, after any coincident commit copy.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            for (int i = 0; i < N; i++) begin
                shadow_r[i] <= 8'd0;
            end
        end else if ((state_r == CHECK) && wr_strobe) begin
            for (int i = 0; i < N; i++) begin
                if (pkt_r[7:0] == 8'(i)) begin
                    shadow_r[i] <= pkt_r[15:8];
                end
            end
        end
    end

    // Display bank copies the whole shadow file at once on commit.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            bars <= '0;
        end else if (commit) begin
            for (int i = 0; i < N; i++) begin
                bars[8*i +: 8] <= shadow_r[i];
            end
        end
    end
endmodule

// File: tb/tb_spi_bar_receiver.sv
// Self-checking bench for spi_bar_receiver: directed scenarios plus random
// frames, checked against a frame-level model of shadow/bank/error state.
module tb_spi_bar_receiver;
    localparam int N = 15;

    logic           clk = 1'b0;
    logic           key0 = 1'b0;
    logic           spi_clk = 1'b0;
    logic           csel = 1'b0;
    logic           mosi = 1'b0;
    logic           commit = 1'b0;
    logic [N*8-1:0] bars;
    logic           wr_strobe;
    logic           pkt_err;
    logic [7:0]     err_count;

    int tests_run = 0;
    int tests_failed = 0;
    int ws_cnt = 0;
    int pe_cnt = 0;
    int m_ws = 0;
    int m_pe = 0;
    int m_err = 0;
    int found = 0;
    logic [7:0] m_shadow [N];
    logic [7:0] m_bars [N];

    spi_bar_receiver #(.N(N), .SYNC_STAGES(2)) dut (
        .CLOCK_50  (clk),
        .KEY0      (key0),
        .spi_clk   (spi_clk),
        .csel      (csel),
        .mosi      (mosi),
        .commit    (commit),
        .bars      (bars),
        .wr_strobe (wr_strobe),
        .pkt_err   (pkt_err),
        .err_count (err_count)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) ws_cnt++;
        if (pkt_err === 1'b1) pe_cnt++;
    end

    initial begin
        #1900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [127:0] m_pack();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[8*i +: 8] = m_bars[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = 8'd0;
            m_bars[i]   = 8'd0;
        end
        m_err = 0;
    endtask

    task automatic model_frame(input int nbits, input logic [7:0] addr, input logic [7:0] data);
        if (nbits == 16 && int'(addr) < N) begin
            m_shadow[int'(addr)] = data;
            m_ws++;
        end else begin
            m_pe++;
            if (m_err < 255) m_err++;
        end
    endtask

    task automatic send_bits(input int nbits, input logic [31:0] v);
        for (int i = 0; i < nbits; i++) begin
            mosi = v[i];
            wait_cycles(4);
            spi_clk = 1'b1;
            wait_cycles(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input int nbits, input logic [31:0] v, input int gap);
        csel = 1'b1;
        wait_cycles(4);
        send_bits(nbits, v);
        csel = 1'b0;
        wait_cycles(gap);
    endtask

    task automatic check_counts(input string tag);
        check_value({tag, "_wr_strobes"}, 128'(ws_cnt), 128'(m_ws));
        check_value({tag, "_pkt_errs"}, 128'(pe_cnt), 128'(m_pe));
        check_value({tag, "_err_count"}, 128'(err_count), 128'(m_err));
    endtask

    task automatic do_frame(input string tag, input int nbits, input logic [7:0] addr, input logic [7:0] data);
        logic [31:0] v;
        v = {16'($urandom), data, addr};
        send_frame(nbits, v, 4);
        wait_cycles(6);
        model_frame(nbits, addr, data);
        check_counts(tag);
        check_value({tag, "_bars_held"}, 128'(bars), m_pack());
    endtask

    task automatic do_commit(input string tag);
        @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        for (int i = 0; i < N; i++) m_bars[i] = m_shadow[i];
        @(negedge clk);
        check_value(tag, 128'(bars), m_pack());
    endtask

    initial begin
        model_reset();
        wait_cycles(5);
        check_value("reset_bars", 128'(bars), 128'(0));
        check_value("reset_err_count", 128'(err_count), 128'(0));
        check_value("reset_wr_strobe", 128'(wr_strobe), 128'(0));
        check_value("reset_pkt_err", 128'(pkt_err), 128'(0));
        key0 = 1'b1;
        wait_cycles(4);

        do_frame("first_write", 16, 8'd3, 8'hA5);
        do_commit("first_commit");
        check_value("first_commit_byte3", 128'(bars[31:24]), 128'(8'hA5));

        do_frame("len15", 15, 8'd2, 8'h11);
        do_frame("len17", 17, 8'd1, 8'h33);
        do_frame("addr_n", 16, 8'd15, 8'h44);
        do_frame("addr_ff", 16, 8'hFF, 8'h55);
        do_commit("bad_frames_commit");

        do_frame("pre_collide", 16, 8'd0, 8'h10);
        do_commit("pre_collide_commit");
        found = 0;
        fork
            send_frame(16, {16'h0000, 8'h20, 8'h00}, 4);
            begin
                for (int k = 0; k < 600 && found == 0; k++) begin
                    @(negedge clk);
                    if (wr_strobe === 1'b1) begin
                        found = 1;
                        commit = 1'b1;
                        @(negedge clk);
                        commit = 1'b0;
                    end
                end
            end
        join
        check_value("collide_strobe_seen", 128'(found), 128'(1));
        for (int i = 0; i < N; i++) m_bars[i] = m_shadow[i];
        model_frame(16, 8'd0, 8'h20);
        wait_cycles(4);
        check_counts("collide");
        check_value("collide_old_value", 128'(bars[7:0]), 128'(8'h10));
        do_commit("collide_next_commit");
        check_value("collide_new_value", 128'(bars[7:0]), 128'(8'h20));

        for (int r = 0; r < 24; r++) begin
            int pick;
            int nb;
            logic [7:0] a;
            logic [7:0] d;
            pick = int'($urandom_range(0, 4));
            nb = (pick == 0) ? 15 : ((pick == 4) ? 17 : 16);
            a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 19));
            d = 8'($urandom);
            do_frame("random", nb, a, d);
            if (r % 4 == 3) do_commit("random_commit");
        end

        csel = 1'b1;
        wait_cycles(4);
        send_bits(8, {16'h0000, 8'h77, 8'h05});
        key0 = 1'b0;
        wait_cycles(3);
        key0 = 1'b1;
        model_reset();
        send_bits(8, 32'h0000_0077);
        csel = 1'b0;
        wait_cycles(10);
        check_counts("midreset");
        check_value("midreset_bars", 128'(bars), 128'(0));
        do_frame("after_reset", 16, 8'd14, 8'hFF);
        do_commit("after_reset_commit");
        check_value("after_reset_bar14", 128'(bars[119:112]), 128'(8'hFF));

        for (int a = 0; a < N; a++) begin
            send_frame(16, {16'h0000, 8'(2 * a), 8'(a)}, 4);
            model_frame(16, 8'(a), 8'(2 * a));
        end
        wait_cycles(8);
        check_counts("b2b");
        do_commit("b2b_commit");

        for (int s = 0; s < 300; s++) begin
            send_frame(15, $urandom, 4);
            model_frame(15, 8'd0, 8'd0);
        end
        wait_cycles(8);
        check_counts("saturate");
        check_value("saturate_value", 128'(err_count), 128'(8'hFF));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
